// File: rtl/ps2_pkg.sv
// Shared definitions for the device-side PS/2 endpoint: FSM encoding, frame
// constants and the parity helper used by both transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_TX,
        ST_RX,
        ST_ACK,
        ST_GAP
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_ACK_CLOCK  = 11;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO holding scancodes queued for the host; head is visible without
// popping so an aborted frame can be retransmitted from the same entry.
module ps2_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        do_push    = push && !full;
        do_pop     = pop && !empty;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define which entries are valid, and leaving it unreset keeps it mappable to RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ps2_device.sv
// Device end of a PS/2 link: clocks queued bytes out to the host, receives
// host commands, and yields the line whenever the host inhibits.
module ps2_device
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 1000,
    parameter int INHIBIT_MIN = 5000,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_out,
    output logic       ps2_data_out,
    output logic       busy
);
    localparam int            HW         = $clog2(HALF_PERIOD + 1);
    localparam int            IW         = $clog2(INHIBIT_MIN + 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] INH_MIN    = IW'(INHIBIT_MIN);
    localparam logic [3:0]    FRAME_LAST = 4'(PS2_FRAME_BITS - 1);
    // Host frames use clocks 1..10; clock 11 belongs to the acknowledge.
    localparam logic [3:0]    RX_LAST    = 4'(PS2_ACK_CLOCK - 2);

    ps2_state_t    state;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_s;
    logic          dat_s;
    logic [HW-1:0] half_cnt;
    logic          half_done;
    logic          phase_low;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [IW-1:0] inh_cnt;
    logic          ack_pend;
    logic          rx_good;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clock_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
        end
    end

    assign clk_s     = clk_sync[1];
    assign dat_s     = dat_sync[1];
    assign half_done = (half_cnt == HALF_LAST);
    assign rx_good   = shreg[9] && (shreg[8] == ps2_odd_parity(shreg[7:0]));
    assign tx_ready  = !fifo_full;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            half_cnt      <= '0;
            phase_low     <= 1'b0;
            bit_cnt       <= '0;
            shreg         <= '0;
            inh_cnt       <= '0;
            ack_pend      <= 1'b0;
            fifo_pop      <= 1'b0;
            ps2_clock_out <= 1'b1;
            ps2_data_out  <= 1'b1;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            fifo_pop <= 1'b0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            half_cnt <= half_done ? '0 : half_cnt + HW'(1);

            case (state)
                ST_IDLE: begin
                    half_cnt  <= '0;
                    phase_low <= 1'b0;
                    bit_cnt   <= '0;
                    if (!clk_s) begin
                        state   <= ST_INHIBIT;
                        inh_cnt <= '0;
                    end else if (!fifo_empty) begin
                        state        <= ST_TX;
                        shreg        <= {1'b1, ps2_odd_parity(fifo_head), fifo_head};
                        ps2_data_out <= 1'b0;
                    end
                end

                ST_INHIBIT: begin
                    if (!clk_s) begin
                        if (inh_cnt != INH_MIN) inh_cnt <= inh_cnt + IW'(1);
                    end else begin
                        half_cnt <= '0;
                        if (!dat_s && inh_cnt == INH_MIN) begin
                            state         <= ST_RX;
                            bit_cnt       <= '0;
                            phase_low     <= 1'b1;
                            ps2_clock_out <= 1'b0;
                        end else begin
                            state     <= ST_GAP;
                            phase_low <= 1'b0;
                        end
                    end
                end

                ST_TX: begin
                    if (half_done) begin
                        if (!phase_low) begin
                            // Host may still claim the line until the tenth edge has gone out.
                            if (!clk_s && bit_cnt < FRAME_LAST) begin
                                state        <= ST_INHIBIT;
                                inh_cnt      <= '0;
                                ps2_data_out <= 1'b1;
                            end else begin
                                phase_low     <= 1'b1;
                                ps2_clock_out <= 1'b0;
                            end
                        end else begin
                            phase_low     <= 1'b0;
                            ps2_clock_out <= 1'b1;
                            if (bit_cnt == FRAME_LAST) begin
                                state        <= ST_GAP;
                                fifo_pop     <= 1'b1;
                                ps2_data_out <= 1'b1;
                            end else begin
                                bit_cnt      <= bit_cnt + 4'd1;
                                ps2_data_out <= shreg[0];
                                shreg        <= {1'b0, shreg[9:1]};
                            end
                        end
                    end
                end

                ST_RX: begin
                    if (half_done) begin
                        if (phase_low) begin
                            shreg         <= {dat_s, shreg[9:1]};
                            phase_low     <= 1'b0;
                            ps2_clock_out <= 1'b1;
                        end else if (!clk_s) begin
                            state   <= ST_INHIBIT;
                            inh_cnt <= '0;
                        end else if (bit_cnt == RX_LAST) begin
                            state        <= ST_ACK;
                            ps2_data_out <= 1'b0;
                        end else begin
                            bit_cnt       <= bit_cnt + 4'd1;
                            phase_low     <= 1'b1;
                            ps2_clock_out <= 1'b0;
                        end
                    end
                end

                ST_ACK: begin
                    if (half_done) begin
                        if (!phase_low) begin
                            phase_low     <= 1'b1;
                            ps2_clock_out <= 1'b0;
                        end else begin
                            state         <= ST_GAP;
                            phase_low     <= 1'b0;
                            ps2_clock_out <= 1'b1;
                            ps2_data_out  <= 1'b1;
                            ack_pend      <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    // Report the received byte one cycle after data is released.
                    if (ack_pend) begin
                        ack_pend <= 1'b0;
                        rx_data  <= shreg[7:0];
                        rx_valid <= rx_good;
                        rx_error <= !rx_good;
                    end
                    if (half_done) begin
                        if (phase_low) begin
                            state     <= ST_IDLE;
                            phase_low <= 1'b0;
                        end else begin
                            phase_low <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: an open-drain host model decodes device frames against
// a byte scoreboard and sends command frames whose results are scoreboarded too.
module tb_ps2_device;
    import ps2_pkg::*;

    localparam int HP    = 20;
    localparam int INH   = 100;
    localparam int DEPTH = 16;

    logic       clock;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       ps2_clock_out;
    logic       ps2_data_out;
    logic       busy;
    logic       host_clk;
    logic       host_data;
    logic       clk_line;
    logic       data_line;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mcount   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    assign clk_line  = ps2_clock_out & host_clk;
    assign data_line = ps2_data_out & host_data;

    ps2_device #(
        .HALF_PERIOD (HP),
        .INHIBIT_MIN (INH),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .ps2_clock_in  (clk_line),
        .ps2_data_in   (data_line),
        .ps2_clock_out (ps2_clock_out),
        .ps2_data_out  (ps2_data_out),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_line_fall(input int budget, output bit ok);
        logic prev;
        prev = clk_line;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (prev && !clk_line) begin
                ok = 1'b1;
                break;
            end
            prev = clk_line;
        end
    endtask

    task automatic wait_line_rise(input int budget, output int len);
        len = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (clk_line) begin
                len = i;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100 * HP) begin
            @(negedge clock);
            n++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic push_byte(input logic [7:0] d);
        bit exp_ready;
        exp_ready = (mcount < DEPTH);
        check("tx_ready", 32'(tx_ready), 32'(exp_ready));
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        if (exp_ready) begin
            tx_q.push_back(d);
            mcount++;
        end
    endtask

    task automatic recv_frame(output logic [10:0] bits, output int edges, output int bad_lows);
        bit ok;
        int len;
        bits     = '0;
        edges    = 0;
        bad_lows = 0;
        for (int b = 0; b < PS2_FRAME_BITS; b++) begin
            wait_line_fall((b == 0) ? 200 * HP : 4 * HP, ok);
            if (!ok) break;
            bits[b] = data_line;
            edges++;
            wait_line_rise(4 * HP, len);
            if (len != HP) bad_lows++;
        end
    endtask

    task automatic recv_and_score(output logic [10:0] bits);
        int         edges;
        int         bad_lows;
        logic [7:0] want;
        recv_frame(bits, edges, bad_lows);
        check("tx_edges", edges, 11);
        check("tx_low_phase", bad_lows, 0);
        check("tx_q_nonempty", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) begin
            want = tx_q.pop_front();
            mcount--;
            check("tx_frame", 32'(bits), 32'({1'b1, ~^want, want, 1'b0}));
        end
    endtask

    task automatic host_send(input logic [7:0] d, input logic par, input bit exp_good);
        bit         ok;
        int         n;
        logic [7:0] want;
        host_clk = 1'b0;
        repeat (INH + 100) @(negedge clock);
        host_data = 1'b0;
        repeat (4) @(negedge clock);
        rx_q.push_back(d);
        host_clk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_line_fall(4 * HP, ok);
            check("rx_clock_fall", 32'(ok), 1);
            if (!ok) begin
                host_data = 1'b1;
                return;
            end
            host_data = (i <= 8) ? d[i-1] : (i == 9) ? par : 1'b1;
        end
        wait_line_fall(4 * HP, ok);
        check("ack_clock_fall", 32'(ok), 1);
        check("ack_data_low", 32'(data_line), 0);
        n = 0;
        while (!data_line && n < 4 * HP) begin
            @(negedge clock);
            n++;
        end
        check("ack_data_release", 32'(data_line), 1);
        check("no_early_flag", 32'({rx_valid, rx_error}), 0);
        @(negedge clock);
        want = rx_q.pop_front();
        check("rx_valid", 32'(rx_valid), 32'(exp_good));
        check("rx_error", 32'(rx_error), 32'(!exp_good));
        check("rx_data", 32'(rx_data), 32'(want));
        @(negedge clock);
        check("flag_one_cycle", 32'({rx_valid, rx_error}), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] bits;
        int          edges;
        int          len;
        bit          ok;

        reset_n   = 1'b0;
        tx_data   = '0;
        tx_valid  = 1'b0;
        host_clk  = 1'b1;
        host_data = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_clock_out", 32'(ps2_clock_out), 1);
        check("rst_data_out", 32'(ps2_data_out), 1);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_error", 32'(rx_error), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        // Single frame: 8'h1C has three ones, so its odd-parity bit is 0.
        push_byte(8'h1C);
        recv_and_score(bits);
        check("tx_1c_literal", 32'(bits), 32'(11'b100_0011_1000));
        wait_idle();

        // Seventeen back-to-back pushes; the last finds the queue full and is dropped.
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        for (int i = 0; i < 16; i++) recv_and_score(bits);
        check("fifo_drained_ready", 32'(tx_ready), 1);
        wait_line_fall(40 * HP, ok);
        check("no_dropped_frame", 32'(ok), 0);
        wait_idle();

        // Host inhibit after the 4th falling edge of 8'hF0, then a full retransmission.
        push_byte(8'hF0);
        edges = 0;
        for (int i = 0; i < 4; i++) begin
            wait_line_fall((i == 0) ? 200 * HP : 4 * HP, ok);
            if (ok) edges++;
        end
        check("inh_pre_edges", edges, 4);
        wait_line_rise(4 * HP, len);
        repeat (3) @(negedge clock);
        host_clk = 1'b0;
        repeat (3 * HP) @(negedge clock);
        check("inh_clock_released", 32'(ps2_clock_out), 1);
        check("inh_data_released", 32'(ps2_data_out), 1);
        check("inh_busy", 32'(busy), 1);
        host_clk = 1'b1;
        recv_and_score(bits);
        wait_idle();

        // 8'hED has six ones, so the correct odd-parity bit is 1.
        host_send(8'hED, 1'b1, 1'b1);
        wait_idle();
        host_send(8'hED, 1'b0, 1'b0);
        wait_idle();

        // Reset during the low phase of the 5th clock of 8'hA5 (data line low there).
        push_byte(8'hA5);
        for (int i = 0; i < 5; i++) wait_line_fall((i == 0) ? 200 * HP : 4 * HP, ok);
        repeat (2) @(negedge clock);
        check("pre_reset_data_low", 32'(ps2_data_out), 0);
        #1 reset_n = 1'b0;
        #1;
        check("reset_clock_out", 32'(ps2_clock_out), 1);
        check("reset_data_out", 32'(ps2_data_out), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_tx_ready", 32'(tx_ready), 1);
        check("reset_rx_data", 32'(rx_data), 0);
        tx_q.delete();
        mcount = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_line_fall(40 * HP, ok);
        check("no_frame_after_reset", 32'(ok), 0);
        check("idle_after_reset", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
